// File: rtl/ripple_ctrl_pkg.sv
// Shared types and defaults for the ripple counter controller.
package ripple_ctrl_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned SETTLE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/cnt_sampler.sv
// Two-flop synchroniser for the asynchronous ripple counter output plus a
// tracked value that only follows samples seen equal in both stages.
module cnt_sampler
  import ripple_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             stable,
  output logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] prev,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] trk_q, trk_d;

  assign stable = (s1_q == s2_q);
  assign sample = s2_q;
  assign prev   = trk_q;
  // value is what the tracker is adopting this cycle, so a capture made in
  // the same cycle sees the freshest stable sample rather than a stale one
  assign value  = stable ? s2_q : trk_q;

  // Next-state for the sampler stages and tracked value
  always_comb begin
    s1_d  = cnt_q;
    s2_d  = s1_q;
    trk_d = trk_q;
    if (stable) begin
      trk_d = s2_q;
    end
    if (clr) begin
      s1_d  = '0;
      s2_d  = '0;
      trk_d = '0;
    end
  end

  // Sampler registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      trk_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      trk_q <= trk_d;
    end
  end

endmodule

// File: rtl/ripple_count_ctrl.sv
// Controller for an external ripple counter: clears it, enables it until the
// synchronised value hits the captured target, wraps, or is stopped, lets it
// settle, then reports the final value with abort/overflow status.
module ripple_count_ctrl
  import ripple_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_rst_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             aborted,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             aborted_q, aborted_d;
  logic             overflow_q, overflow_d;

  logic             smp_stable;
  logic [WIDTH-1:0] smp_sample;
  logic [WIDTH-1:0] smp_prev;
  logic [WIDTH-1:0] smp_value;
  logic             match;
  logic             wrap;

  cnt_sampler #(
    .WIDTH (WIDTH)
  ) u_sampler (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == CLEAR),
    .cnt_q  (cnt_q),
    .stable (smp_stable),
    .sample (smp_sample),
    .prev   (smp_prev),
    .value  (smp_value)
  );

  assign match = smp_stable && (smp_sample == tgt_q);
  assign wrap  = smp_stable && (smp_sample < smp_prev);

  // Next-state, run status and result capture
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    settle_d   = settle_q;
    result_d   = result_q;
    aborted_d  = aborted_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d      = target;
          result_d   = '0;
          aborted_d  = 1'b0;
          overflow_d = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        settle_d = '0;
        state_d  = (tgt_q == '0) ? SETTLE : RUN;
      end
      RUN: begin
        // match outranks wrap, which outranks stop
        settle_d = '0;
        if (match) begin
          state_d = SETTLE;
        end else if (wrap) begin
          overflow_d = 1'b1;
          state_d    = SETTLE;
        end else if (stop) begin
          aborted_d = 1'b1;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == 4'(SETTLE_CYC - 1)) begin
          result_d = smp_value;
          state_d  = DONE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers, forced to idle by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      settle_q   <= '0;
      result_q   <= '0;
      aborted_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      settle_q   <= settle_d;
      result_q   <= result_d;
      aborted_q  <= aborted_d;
      overflow_q <= overflow_d;
    end
  end

  // Enable drops in the cycle the exit from RUN is decided, so the counter
  // does not advance past the value that caused the exit
  assign cnt_en    = (state_q == RUN) && (state_d == RUN);
  assign cnt_rst_n = reset && (state_q != CLEAR);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign aborted   = aborted_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl with a slow behavioural counter (one step per
// four enabled clocks) so the synchronised value has time to become stable.
module tb_ripple_count_ctrl;

  localparam int unsigned W      = 8;
  localparam int unsigned SC     = 2;
  localparam int unsigned BUDGET = 3000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] cnt_q;
  logic         cnt_en, cnt_rst_n, busy, done, aborted, overflow;
  logic [W-1:0] result;

  logic [W-1:0] ctr = '0;
  logic [1:0]   div = '0;
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  int unsigned done_cnt = 0, clr_cnt = 0, en_cnt = 0;
  int unsigned d0, c0, e0;

  ripple_count_ctrl #(.WIDTH(W), .SETTLE_CYC(SC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .target    (target),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_rst_n (cnt_rst_n),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .aborted   (aborted),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign cnt_q = force_en ? force_val : ctr;

  // External counter: cleared by cnt_rst_n, steps every fourth enabled clock
  always @(posedge clk) begin
    if (!cnt_rst_n) begin
      ctr <= '0;
      div <= '0;
    end else if (cnt_en) begin
      div <= div + 2'd1;
      if (div == 2'd3) ctr <= ctr + 1'b1;
    end
  end

  // Cycle counters for done pulses, clear pulses and enabled cycles
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (reset && cnt_rst_n === 1'b0) clr_cnt++;
    if (cnt_en === 1'b1) en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a run and wait for done; optional one-shot stop when the counter
  // shows stop_at at divider phase stop_ph; a stray start mid-run must be ignored
  task automatic run(input logic [W-1:0] tgt, input bit do_stop, input logic [W-1:0] stop_at,
                     input logic [1:0] stop_ph, output bit seen, output int unsigned cyc);
    bit fired;
    fired = 1'b0;
    d0 = done_cnt; c0 = clr_cnt; e0 = en_cnt;
    target = tgt;
    start = 1'b1;
    tick();
    start = 1'b0;
    target = ~tgt;
    check("busy_after_start", busy, 1);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        start = (cyc == 3);
        stop = do_stop && !fired && (cyc >= 2) && (ctr == stop_at) && (div == stop_ph);
        if (stop) fired = 1'b1;
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  // Outputs during the done cycle, then one-cycle pulse and held status
  task automatic verify(input string tag, input bit seen, input logic [W-1:0] lo,
                        input logic [W-1:0] hi, input bit ea, input bit eo);
    logic [W-1:0] held;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_result_range"}, (result >= lo) && (result <= hi), 1);
    check({tag, "_aborted"}, aborted, ea);
    check({tag, "_overflow"}, overflow, eo);
    held = result;
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_result_held"}, result, held);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_clr_pulses"}, clr_cnt - c0, 1);
  endtask

  initial begin
    bit           seen;
    int unsigned  cyc;
    logic [W-1:0] tgt, k;
    bit           ds;

    // Reset state
    repeat (3) tick();
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_rst_n", cnt_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_aborted", aborted, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    #1;
    check("idle_cnt_rst_n", cnt_rst_n, 1);
    tick();

    // Plain run to target 5
    run(8'd5, 1'b0, '0, 2'd0, seen, cyc);
    verify("t5", seen, 8'd5, 8'd5, 1'b0, 1'b0);
    check("t5_enabled", (en_cnt - e0) > 0, 1);

    // Target 0: no enable, fixed latency
    run(8'd0, 1'b0, '0, 2'd0, seen, cyc);
    check("t0_latency", cyc, 1 + SC + 1);
    check("t0_no_enable", en_cnt - e0, 0);
    verify("t0", seen, 8'd0, 8'd0, 1'b0, 1'b0);

    // Stop once the counter reaches 50
    run(8'd200, 1'b1, 8'd50, 2'd0, seen, cyc);
    verify("stop50", seen, 8'd50, 8'd52, 1'b1, 1'b0);

    // Stop in the very cycle the stable value equals target: match wins
    run(8'd10, 1'b1, 8'd10, 2'd2, seen, cyc);
    verify("stop_match", seen, 8'd10, 8'd10, 1'b0, 1'b0);

    // Wrap: counter forced to 255 then 0
    d0 = done_cnt; c0 = clr_cnt;
    target = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    force_val = 8'd255;
    force_en = 1'b1;
    repeat (4) tick();
    force_val = 8'd0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 50 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    verify("wrap", seen, 8'd0, 8'd0, 1'b0, 1'b1);
    force_en = 1'b0;

    // Randomised runs against the reference: result is target unless stopped
    // earlier at count k, in which case result is k and aborted is set
    for (int unsigned i = 0; i < 6; i++) begin
      tgt = 8'($urandom_range(2, 20));
      ds  = 1'($urandom_range(0, 1));
      k   = 8'($urandom_range(1, int'(tgt) - 1));
      run(tgt, ds, k, 2'd0, seen, cyc);
      verify($sformatf("rand%0d", i), seen, ds ? k : tgt, ds ? k : tgt, ds, 1'b0);
    end

    // Reset in the middle of a run at count 30
    d0 = done_cnt;
    target = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 400 && !seen; i++) begin
      if (ctr == 8'd30) seen = 1'b1;
      else tick();
    end
    check("mid_reached_30", seen, 1);
    check("mid_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_cnt_en", cnt_en, 0);
    check("mid_cnt_rst_n", cnt_rst_n, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_result", result, 0);
    check("mid_aborted", aborted, 0);
    check("mid_overflow", overflow, 0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("mid_rel_cnt_rst_n", cnt_rst_n, 1);
    check("mid_rel_busy", busy, 0);
    repeat (3) tick();
    check("mid_no_done", done_cnt - d0, 0);
    run(8'd7, 1'b0, '0, 2'd0, seen, cyc);
    verify("after_rst", seen, 8'd7, 8'd7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
